pulse_capture: RTL and testbench

- One-shot pulse-width capture timer: the measuring counterpart of the one-shot pulse generator in the timer library.
- Once armed, it waits for a rising edge on a synchronous input, counts the cycles the input stays high, and presents the width with a one-cycle done strobe.
- Used to measure strobes and enables produced by pulse timers and peripherals.

---
 rtl/pulse_capture_pkg.sv | 16 +
 rtl/pulse_capture_edge_detect.sv | 24 ++
 rtl/pulse_capture.sv | 105 ++++++++++
 tb/tb_pulse_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_capture_pkg.sv
// Shared types for the one-shot pulse-width capture timer.
// Holds the capture FSM state encoding used by pulse_capture.
package pulse_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cur, input logic [31:0] max);
        return (cur == max) ? cur : cur + 32'd1;
    endfunction

endpackage

// File: rtl/pulse_capture_edge_detect.sv
// Single-bit edge detector: registers d and flags rising/falling transitions.
// Reusable across the timer library; asynchronous active-low reset.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/pulse_capture.sv
// One-shot pulse-width capture: once armed, measures how many cycles sig stays
// high after a rising edge and reports the width with a one-cycle done strobe.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         arm,
    input  logic         cancel,
    input  logic         sig,
    output logic [W-1:0] value,
    output logic         done,
    output logic         busy,
    output logic         ovf
);

    state_t       state, state_next;
    logic [W-1:0] count, count_next;
    logic [W-1:0] value_next;
    logic         ovf_next;
    logic         done_next;
    logic         sat, sat_next;
    logic         rise, fall;

    edge_detect u_edge (
        .clock (clock),
        .reset (reset),
        .d     (sig),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            value <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            value <= value_next;
            ovf   <= ovf_next;
            done  <= done_next;
            sat   <= sat_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        value_next = value;
        ovf_next   = ovf;
        sat_next   = sat;
        done_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // cancel and sig edges have no effect until armed
                if (arm) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (rise) begin
                    state_next = ST_MEASURE;
                    count_next = W'(1);
                    sat_next   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (sig) begin
                    if (count == '1) begin
                        sat_next = 1'b1;
                    end
                    count_next = W'(sat_inc(32'(count), 32'(W'('1))));
                end else if (fall) begin
                    value_next = count;
                    ovf_next   = sat;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture with a scoreboard of expected captures,
// run on a W=4 instance (saturation) and a default W=8 instance in parallel.
module tb_pulse_capture;

    typedef struct packed {
        logic [7:0] v;
        logic       o;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       arm;
    logic       cancel;
    logic       sig;
    logic [3:0] value4;
    logic       done4, busy4, ovf4;
    logic [7:0] value8;
    logic       done8, busy8, ovf8;

    int   checks   = 0;
    int   failures = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    pulse_capture #(.W(4)) dut4 (
        .clock  (clock),
        .reset  (reset),
        .arm    (arm),
        .cancel (cancel),
        .sig    (sig),
        .value  (value4),
        .done   (done4),
        .busy   (busy4),
        .ovf    (ovf4)
    );

    pulse_capture #(.W(8)) dut8 (
        .clock  (clock),
        .reset  (reset),
        .arm    (arm),
        .cancel (cancel),
        .sig    (sig),
        .value  (value8),
        .done   (done8),
        .busy   (busy8),
        .ovf    (ovf8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cap(input logic [7:0] v4, input logic o4, input logic [7:0] v8, input logic o8);
        q4.push_back('{v: v4, o: o4});
        q8.push_back('{v: v8, o: o8});
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clock);
        arm = 1'b0;
    endtask

    // sig is high for exactly n sampling edges
    task automatic pulse(input int n);
        sig = 1'b1;
        repeat (n) @(negedge clock);
        sig = 1'b0;
    endtask

    task automatic finish_capture(input string tag);
        @(negedge clock);
        check({tag, "_done4"}, done4, 1'b1);
        check({tag, "_done8"}, done8, 1'b1);
        check({tag, "_busy_low"}, busy4, 1'b0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done4, 1'b0);
    endtask

    // Scoreboard: every done must match the oldest expected capture.
    always @(negedge clock) begin
        if (done4) begin
            checks++;
            assert (q4.size() != 0) else begin
                failures++;
                $error("FAIL done4_unexpected observed=done expected=no_done");
            end
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("sb_value4", value4, e4.v[3:0]);
                check("sb_ovf4", ovf4, e4.o);
            end
        end
        if (done8) begin
            checks++;
            assert (q8.size() != 0) else begin
                failures++;
                $error("FAIL done8_unexpected observed=done expected=no_done");
            end
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("sb_value8", value8, e8.v);
                check("sb_ovf8", ovf8, e8.o);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        arm    = 1'b0;
        cancel = 1'b0;
        sig    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_value", value4, 4'd0);
        check("rst_done", done4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_ovf", ovf4, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        // basic 3-cycle pulse
        do_arm();
        check("armed_busy", busy4, 1'b1);
        expect_cap(8'd3, 1'b0, 8'd3, 1'b0);
        pulse(3);
        finish_capture("basic");

        // long pulse saturates the narrow instance only
        do_arm();
        expect_cap(8'd15, 1'b1, 8'd20, 1'b0);
        pulse(20);
        finish_capture("sat20");

        // exactly all-ones width is not an overflow
        do_arm();
        expect_cap(8'd15, 1'b0, 8'd15, 1'b0);
        pulse(15);
        finish_capture("edge15");

        // sig already high when armed: partial pulse is skipped
        sig = 1'b1;
        do_arm();
        repeat (2) @(negedge clock);
        sig = 1'b0;
        repeat (2) @(negedge clock);
        expect_cap(8'd4, 1'b0, 8'd4, 1'b0);
        pulse(4);
        finish_capture("prehigh");

        // cancel mid-measure keeps previous result
        do_arm();
        sig = 1'b1;
        repeat (2) @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        sig    = 1'b0;
        repeat (3) @(negedge clock);
        check("cancel_busy", busy4, 1'b0);
        check("cancel_value_kept", value4, 4'd4);
        do_arm();
        expect_cap(8'd1, 1'b0, 8'd1, 1'b0);
        pulse(1);
        finish_capture("one");

        // pulse without arm is ignored
        pulse(3);
        check("noarm_busy", busy4, 1'b0);
        repeat (3) @(negedge clock);
        check("noarm_value", value4, 4'd1);

        // arm together with cancel in IDLE still arms
        arm    = 1'b1;
        cancel = 1'b1;
        @(negedge clock);
        arm    = 1'b0;
        cancel = 1'b0;
        check("armcancel_busy", busy4, 1'b1);
        expect_cap(8'd3, 1'b0, 8'd3, 1'b0);
        pulse(3);
        finish_capture("armcancel");

        // re-arm during the done cycle; a rise in that cycle is not counted
        do_arm();
        expect_cap(8'd3, 1'b0, 8'd3, 1'b0);
        pulse(3);
        @(negedge clock);
        check("rearm_done", done4, 1'b1);
        arm = 1'b1;
        sig = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        sig = 1'b0;
        check("rearm_busy", busy4, 1'b1);
        @(negedge clock);
        expect_cap(8'd2, 1'b0, 8'd2, 1'b0);
        pulse(2);
        finish_capture("rearm2");

        // asynchronous reset in the middle of a measurement
        do_arm();
        sig = 1'b1;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("amid_value4", value4, 4'd0);
        check("amid_value8", value8, 8'd0);
        check("amid_done", done4, 1'b0);
        check("amid_busy4", busy4, 1'b0);
        check("amid_busy8", busy8, 1'b0);
        sig = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_rst_busy", busy4, 1'b0);

        check("q4_drained", q4.size(), 0);
        check("q8_drained", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
